// File: rtl/stdp_pkg.sv
// Shared STDP synapse constants, FSM state encoding and the dt-to-step mapping.
package stdp_pkg;
  localparam int WEIGHT_W = 8;
  localparam int CNT_W = 4;
  localparam logic [WEIGHT_W-1:0] W_INIT = 8'd128;
  localparam int A_MAX = 16;

  typedef enum logic {IDLE, APPLY} state_t;

  // Step size halves for every quarter of the timing window.
  function automatic logic [WEIGHT_W-1:0] step(input logic [CNT_W-1:0] dt);
    logic [WEIGHT_W-1:0] amax;
    amax = WEIGHT_W'(A_MAX);
    return amax >> dt[CNT_W-1:CNT_W-2];
  endfunction
endpackage

// File: rtl/spike_timer.sv
// Cycles since the last spike, valid for 2**CNT_W cycles after it; no backpressure.
module spike_timer
  import stdp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt,
  output logic             vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      vld <= 1'b0;
    end else if (spike) begin
      cnt <= '0;
      vld <= 1'b1;
    end else if (vld) begin
      // Saturated count ends the window instead of wrapping.
      if (cnt == {CNT_W{1'b1}}) vld <= 1'b0;
      else cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: update captured on the triggering spike, applied one cycle later;
// syn_current is the registered weight gated by pre_spike. No backpressure.
module stdp_synapse
  import stdp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic                learn_en,
  output logic [WEIGHT_W-1:0] weight,
  output logic [WEIGHT_W-1:0] syn_current,
  output logic [CNT_W-1:0]    time_diff,
  output logic                update_w_flag,
  output logic                ltp
);

  logic [CNT_W-1:0]    pre_cnt, post_cnt, cap_dt, dt_q;
  logic                pre_vld, post_vld;
  logic                ltp_ev, ltd_ev, capture, apply, dir_q;
  logic [WEIGHT_W-1:0] step_q, w_next;
  logic [WEIGHT_W:0]   sum, diff;
  state_t              state, next_state;

  spike_timer u_pre_timer (
    .clk   (clk),
    .rst   (rst),
    .spike (pre_spike),
    .cnt   (pre_cnt),
    .vld   (pre_vld)
  );

  spike_timer u_post_timer (
    .clk   (clk),
    .rst   (rst),
    .spike (post_spike),
    .cnt   (post_cnt),
    .vld   (post_vld)
  );

  // Coincident spikes qualify neither direction.
  assign ltp_ev  = learn_en & post_spike & ~pre_spike & pre_vld;
  assign ltd_ev  = learn_en & pre_spike & ~post_spike & post_vld;
  assign capture = ltp_ev | ltd_ev;
  assign cap_dt  = ltp_ev ? pre_cnt : post_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    apply      = 1'b0;
    case (state)
      IDLE:  if (capture) next_state = APPLY;
      APPLY: begin
        apply = 1'b1;
        if (capture) next_state = APPLY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_q   <= '0;
      dir_q  <= 1'b0;
      step_q <= '0;
    end else if (capture) begin
      dt_q   <= cap_dt;
      dir_q  <= ltp_ev;
      step_q <= step(cap_dt);
    end
  end

  // One extra bit carries overflow/borrow for clamping.
  always_comb begin
    sum  = {1'b0, weight} + {1'b0, step_q};
    diff = {1'b0, weight} - {1'b0, step_q};
    if (dir_q) w_next = sum[WEIGHT_W]  ? {WEIGHT_W{1'b1}} : sum[WEIGHT_W-1:0];
    else       w_next = diff[WEIGHT_W] ? '0               : diff[WEIGHT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight        <= W_INIT;
      syn_current   <= '0;
      time_diff     <= '0;
      update_w_flag <= 1'b0;
      ltp           <= 1'b0;
    end else begin
      syn_current   <= pre_spike ? weight : '0;
      update_w_flag <= apply;
      if (apply) begin
        weight    <= w_next;
        time_diff <= dt_q;
        ltp       <= dir_q;
      end
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed STDP pairs; expected updates go to a scoreboard queue checked whenever update_w_flag pulses.
module tb_stdp_synapse;

  logic       clk, rst, pre_spike, post_spike, learn_en;
  logic [7:0] weight, syn_current;
  logic [3:0] time_diff;
  logic       update_w_flag, ltp;

  typedef struct {
    int w;
    int dt;
    int dir;
  } upd_t;

  upd_t exp_q[$];
  int   syn_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   syn_chk_en = 0;

  stdp_synapse dut (
    .clk           (clk),
    .rst           (rst),
    .pre_spike     (pre_spike),
    .post_spike    (post_spike),
    .learn_en      (learn_en),
    .weight        (weight),
    .syn_current   (syn_current),
    .time_diff     (time_diff),
    .update_w_flag (update_w_flag),
    .ltp           (ltp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every flag pulse must match the oldest expected update.
  initial begin
    upd_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && update_w_flag) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_update: got w=%0d dt=%0d ltp=%0d want no update",
                   weight, time_diff, ltp);
        end else begin
          e = exp_q.pop_front();
          if (weight != e.w || time_diff != e.dt || ltp != e.dir) begin
            errors++;
            $display("FAIL update: got w=%0d dt=%0d ltp=%0d want w=%0d dt=%0d ltp=%0d",
                     weight, time_diff, ltp, e.w, e.dt, e.dir);
          end
        end
      end
      if (!rst && syn_chk_en && syn_current != 0) begin
        checks++;
        if (syn_q.size() == 0) begin
          errors++;
          $display("FAIL syn_current_extra: got %0d want 0", syn_current);
        end else if (syn_current != syn_q.pop_front()) begin
          errors++;
          $display("FAIL syn_current: got %0d want expected weight", syn_current);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spike(input logic p, input logic q);
    pre_spike  = p;
    post_spike = q;
    @(negedge clk);
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic push(input int w, input int dt, input int dir);
    upd_t e;
    e.w = w; e.dt = dt; e.dir = dir;
    exp_q.push_back(e);
  endtask

  task automatic ltp_pair(input int dt, input int exp_w);
    push(exp_w, dt, 1);
    spike(1'b1, 1'b0);
    idle(dt);
    spike(1'b0, 1'b1);
    idle(20);
  endtask

  task automatic ltd_pair(input int dt, input int exp_w);
    push(exp_w, dt, 0);
    spike(1'b0, 1'b1);
    idle(dt);
    spike(1'b1, 1'b0);
    idle(20);
  endtask

  initial begin
    rst = 1'b1; pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1;
    idle(2);
    chk("rst_weight", weight, 128);
    chk("rst_syn", syn_current, 0);
    chk("rst_time_diff", time_diff, 0);
    chk("rst_flag", update_w_flag, 0);
    chk("rst_ltp", ltp, 0);
    rst = 1'b0;
    idle(3);

    ltp_pair(1, 144);
    ltd_pair(13, 142);

    // k=18: outside the window
    spike(1'b1, 1'b0);
    idle(17);
    spike(1'b0, 1'b1);
    idle(20);
    chk("out_of_window_weight", weight, 142);

    syn_chk_en = 1'b1;
    syn_q.push_back(142);
    spike(1'b1, 1'b0);
    chk("syn_pulse_next_cycle", syn_current, 142);
    idle(1);
    chk("syn_zero_after", syn_current, 0);
    idle(3);
    syn_chk_en = 1'b0;
    chk("syn_queue_drained", syn_q.size(), 0);
    idle(20);

    // Coincident spikes restart both timers: the later post sees dt=2, not 7.
    push(158, 2, 1);
    spike(1'b1, 1'b0);
    idle(4);
    spike(1'b1, 1'b1);
    idle(2);
    spike(1'b0, 1'b1);
    idle(20);
    chk("simul_weight", weight, 158);

    learn_en = 1'b0;
    spike(1'b1, 1'b0);
    idle(2);
    spike(1'b0, 1'b1);
    idle(20);
    chk("frozen_weight", weight, 158);
    learn_en = 1'b1;

    // Back-to-back: LTP then LTD on consecutive cycles.
    push(174, 0, 1);
    push(158, 0, 0);
    spike(1'b1, 1'b0);
    spike(1'b0, 1'b1);
    spike(1'b1, 1'b0);
    idle(20);

    // Reset during APPLY drops the pending update.
    spike(1'b1, 1'b0);
    spike(1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_weight", weight, 128);
    chk("midrst_flag", update_w_flag, 0);
    chk("midrst_syn", syn_current, 0);
    chk("midrst_time_diff", time_diff, 0);
    @(negedge clk);
    idle(1);
    rst = 1'b0;
    idle(20);
    chk("after_midrst_weight", weight, 128);

    for (int i = 1; i <= 17; i++) ltp_pair(0, (128 + 16 * i > 255) ? 255 : 128 + 16 * i);
    chk("sat_high", weight, 255);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    for (int i = 1; i <= 7; i++) ltd_pair(0, 128 - 16 * i);
    ltd_pair(8, 12);
    ltd_pair(12, 10);
    for (int i = 0; i < 10; i++) ltd_pair(0, 0);
    chk("sat_low", weight, 0);

    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
